// File: rtl/timebase_nco.sv
// timebase_nco: multi-channel NCO timebase. Each channel adds a runtime
// programmable increment into a phase accumulator every clock; the carry out
// becomes a one-cycle tick and toggles a half-rate square wave. Channel 0 is
// the RTC tick source, channel 1 the UART baud tick source.
// Increments/enables are changed through a small config FSM that defers the
// commit to a glitch-free point (channel idle, inc==0, or the carry edge).
// Optional: define TIMEBASE_TICK_COUNT_EN to add per-channel 32-bit tick
// counters on output tick_cnt.
//
// Config handshake: a request transfers on a rising edge where
// cfg_valid && cfg_ready. cfg_ready is high only in IDLE, so after a transfer
// the request is held in a shadow register and cfg_valid is ignored until the
// FSM returns to IDLE (at least one cycle later).
module timebase_nco #(
  parameter int                  CH      = 2,
  parameter int                  ACC_W   = 32,
  parameter logic [CH*ACC_W-1:0] INC_RST = {32'd19791209, 32'd5629499},
  parameter logic [CH-1:0]       EN_RST  = 2'b11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_en,
  input  logic [CH-1:0]    sync_clear,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    half_clk,
  output logic             busy
`ifdef TIMEBASE_TICK_COUNT_EN
  ,
  output logic [CH*32-1:0] tick_cnt
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [3:0] CH_L = 4'(CH);

  state_t           state_q;
  logic [2:0]       shd_ch_q;
  logic [ACC_W-1:0] shd_inc_q;
  logic             shd_en_q;

  logic [ACC_W-1:0] acc_q [CH];
  logic [ACC_W-1:0] inc_q [CH];
  logic [CH-1:0]    en_q;
  logic [CH-1:0]    tick_q;
  logic [CH-1:0]    half_q;
`ifdef TIMEBASE_TICK_COUNT_EN
  logic [31:0]      cnt_q [CH];
`endif

  logic [ACC_W:0]   sum_d [CH];
  logic [CH-1:0]    carry_d;
  logic [CH-1:0]    commit_d;
  logic             shd_oor_d;

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = ~cfg_ready;
  assign tick      = tick_q;
  assign half_clk  = half_q;

`ifdef TIMEBASE_TICK_COUNT_EN
  for (genvar g = 0; g < CH; g++) begin : g_cnt_out
    assign tick_cnt[g*32 +: 32] = cnt_q[g];
  end
`endif

  // Wide sums, carries and the per-channel commit decision for a pending config
  always_comb begin
    carry_d   = '0;
    commit_d  = '0;
    shd_oor_d = ({1'b0, shd_ch_q} >= CH_L);
    for (int i = 0; i < CH; i++) begin
      sum_d[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      carry_d[i]  = en_q[i] & sum_d[i][ACC_W];
      // A carry blocked by sync_clear does not count as a safe commit point
      commit_d[i] = (state_q == S_WAIT) && (shd_ch_q == 3'(i)) &&
                    (~en_q[i] || (inc_q[i] == '0) || (carry_d[i] && ~sync_clear[i]));
    end
  end

  // Config FSM: capture a request into the shadow, then wait for its commit point
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shd_ch_q  <= '0;
      shd_inc_q <= '0;
      shd_en_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            shd_ch_q  <= cfg_ch;
            shd_inc_q <= cfg_inc;
            shd_en_q  <= cfg_en;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Out-of-range channels are dropped after a single WAIT cycle
          if (shd_oor_d || (|commit_d)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Per-channel accumulation, tick/half-clock generation and increment commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_RST[i*ACC_W +: ACC_W];
`ifdef TIMEBASE_TICK_COUNT_EN
        cnt_q[i] <= '0;
`endif
      end
      en_q   <= EN_RST;
      tick_q <= '0;
      half_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sync_clear[i]) begin
          acc_q[i]  <= '0;
          tick_q[i] <= 1'b0;
          half_q[i] <= 1'b0;
`ifdef TIMEBASE_TICK_COUNT_EN
          cnt_q[i]  <= '0;
`endif
        end else if (commit_d[i] && !shd_en_q) begin
          // Disabling: phase and square wave restart from zero, a carry tick still goes out
          acc_q[i]  <= '0;
          tick_q[i] <= carry_d[i];
          half_q[i] <= 1'b0;
`ifdef TIMEBASE_TICK_COUNT_EN
          cnt_q[i]  <= '0;
`endif
        end else if (en_q[i]) begin
          acc_q[i]  <= sum_d[i][ACC_W-1:0];
          tick_q[i] <= carry_d[i];
          half_q[i] <= half_q[i] ^ carry_d[i];
`ifdef TIMEBASE_TICK_COUNT_EN
          cnt_q[i]  <= cnt_q[i] + 32'(carry_d[i]);
`endif
        end else begin
          acc_q[i]  <= '0;
          tick_q[i] <= 1'b0;
          half_q[i] <= 1'b0;
        end
        // New increment takes effect on the following add
        if (commit_d[i]) begin
          inc_q[i] <= shd_inc_q;
          en_q[i]  <= shd_en_q;
        end
      end
    end
  end

endmodule
